// File: rtl/sprite_window_renderer.sv
// Draws one ROM sprite into a fixed screen window with integer scaling, per-frame
// wrap-around horizontal scroll and an optional transparent index; 3-clock latency.
module sprite_window_renderer #(
    parameter int SPR_W      = 540,
    parameter int SPR_H      = 82,
    parameter int X0         = 0,
    parameter int Y0         = 398,
    parameter int SCALE_X    = 1,
    parameter int SCALE_Y    = 1,
    parameter int AW         = 16,
    parameter int IDX_W      = 9,
    parameter int TRANSP_EN  = 1,
    parameter int TRANSP_IDX = 0
) (
    input  logic             vga_clk,
    input  logic             Reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic [9:0]       scroll_x,
    output logic [AW-1:0]    rom_addr,
    input  logic [IDX_W-1:0] rom_q,
    output logic [IDX_W-1:0] pal_index,
    input  logic [3:0]       pal_red,
    input  logic [3:0]       pal_green,
    input  logic [3:0]       pal_blue,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             pix_valid
);

    localparam int WIN_W = SPR_W * SCALE_X;
    localparam int WIN_H = SPR_H * SCALE_Y;
    localparam int CW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int XSW   = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int YSW   = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    localparam logic [CW-1:0]  COL_LAST  = CW'(SPR_W - 1);
    localparam logic [XSW-1:0] XSUB_LAST = XSW'(SCALE_X - 1);
    localparam logic [YSW-1:0] YSUB_LAST = YSW'(SCALE_Y - 1);
    localparam logic [AW-1:0]  ROW_STEP  = AW'(SPR_W);

    if (SCALE_X < 1 || SCALE_Y < 1) begin : g_bad_scale
        $error("sprite_window_renderer: SCALE_X and SCALE_Y must be >= 1");
    end
    if (X0 + WIN_W > 640 || Y0 + WIN_H > 480) begin : g_bad_window
        $error("sprite_window_renderer: window does not fit on a 640x480 screen");
    end
    if ((2 ** AW) < SPR_W * SPR_H) begin : g_bad_aw
        $error("sprite_window_renderer: AW too small for SPR_W*SPR_H texels");
    end

    logic [9:0]       x_s_q, x_s_d, y_s_q, y_s_d;
    logic             blank_s_q, blank_s_d;
    logic [CW-1:0]    scl_q, scl_d;
    logic             synced_q, synced_d;
    logic [CW-1:0]    col_q, col_d, col_cur;
    logic [XSW-1:0]   xsub_q, xsub_d, xsub_cur;
    logic [AW-1:0]    rowbase_q, rowbase_d, rowbase_cur;
    logic [YSW-1:0]   ysub_q, ysub_d, ysub_cur;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic             ok1_q, ok1_d, ok2_q, ok2_d;
    logic [3:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             pix_valid_q, pix_valid_d;

    logic [11:0]      dx, dy;
    logic             in_win, row_start, first_row, transp;

    always_comb begin
        x_s_d     = DrawX;
        y_s_d     = DrawY;
        blank_s_d = blank;

        // Scroll is only taken at frame start, saturated to the last texel column.
        scl_d    = scl_q;
        synced_d = synced_q;
        if (DrawX == 10'd0 && DrawY == 10'd0) begin
            synced_d = 1'b1;
            scl_d    = ({1'b0, scroll_x} >= 11'(SPR_W - 1)) ? COL_LAST : CW'(scroll_x);
        end

        // Offsets wrap to huge values left of / above the window, so one compare suffices.
        dx        = {2'b00, x_s_q} - 12'(X0);
        dy        = {2'b00, y_s_q} - 12'(Y0);
        in_win    = (dx < 12'(WIN_W)) && (dy < 12'(WIN_H));
        row_start = (dx == 12'd0);
        first_row = (dy == 12'd0);

        col_cur     = col_q;
        xsub_cur    = xsub_q;
        rowbase_cur = rowbase_q;
        ysub_cur    = ysub_q;
        if (in_win && row_start) begin
            col_cur  = scl_q;
            xsub_cur = '0;
            if (first_row) begin
                rowbase_cur = '0;
                ysub_cur    = '0;
            end else if (ysub_q == YSUB_LAST) begin
                rowbase_cur = rowbase_q + ROW_STEP;
                ysub_cur    = '0;
            end else begin
                ysub_cur = ysub_q + YSW'(1);
            end
        end

        col_d     = col_q;
        xsub_d    = xsub_q;
        rowbase_d = rowbase_cur;
        ysub_d    = ysub_cur;
        if (in_win) begin
            if (xsub_cur == XSUB_LAST) begin
                xsub_d = '0;
                col_d  = (col_cur == COL_LAST) ? '0 : col_cur + CW'(1);
            end else begin
                xsub_d = xsub_cur + XSW'(1);
                col_d  = col_cur;
            end
        end

        rom_addr_d = rom_addr_q;
        if (in_win && blank_s_q) begin
            rom_addr_d = rowbase_cur + AW'(col_cur);
        end

        ok1_d = in_win && blank_s_q && synced_q;
        ok2_d = ok1_q;

        // pix_valid qualifies red/green/blue in the same cycle; no back-pressure exists.
        transp      = (TRANSP_EN != 0) && (rom_q == IDX_W'(TRANSP_IDX));
        pix_valid_d = ok2_q && !transp;
        red_d       = pix_valid_d ? pal_red   : 4'd0;
        green_d     = pix_valid_d ? pal_green : 4'd0;
        blue_d      = pix_valid_d ? pal_blue  : 4'd0;
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            x_s_q       <= '0;
            y_s_q       <= '0;
            blank_s_q   <= 1'b0;
            scl_q       <= '0;
            synced_q    <= 1'b0;
            col_q       <= '0;
            xsub_q      <= '0;
            rowbase_q   <= '0;
            ysub_q      <= '0;
            rom_addr_q  <= '0;
            ok1_q       <= 1'b0;
            ok2_q       <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            x_s_q       <= x_s_d;
            y_s_q       <= y_s_d;
            blank_s_q   <= blank_s_d;
            scl_q       <= scl_d;
            synced_q    <= synced_d;
            col_q       <= col_d;
            xsub_q      <= xsub_d;
            rowbase_q   <= rowbase_d;
            ysub_q      <= ysub_d;
            rom_addr_q  <= rom_addr_d;
            ok1_q       <= ok1_d;
            ok2_q       <= ok2_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pal_index = rom_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_sprite_window_renderer.sv
// Randomized raster bench for sprite_window_renderer: two instances (scaled/offset
// window with transparency, and origin window without) against a texel-formula model.
module tb_sprite_window_renderer;

    localparam int SW0 = 7, SH0 = 4, X00 = 3, Y00 = 2, SX0 = 2, SY0 = 3, AW0 = 6;
    localparam int TE0 = 1, TI0 = 0;
    localparam int SW1 = 5, SH1 = 3, X01 = 0, Y01 = 0, SX1 = 1, SY1 = 1, AW1 = 4;
    localparam int TE1 = 0, TI1 = 0;
    localparam int HT = 24, VT = 18, HACT = 20, VACT = 16, NF = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [9:0] draw_x = 10'(HT - 1);
    logic [9:0] draw_y = 10'(VT - 1);
    logic [9:0] scroll_x = '0;
    logic       blank = 1'b0;

    logic [AW0-1:0] addr0;
    logic [3:0]     q0, pi0, pr0, pg0, pb0, r0, g0, b0;
    logic           v0;
    logic [AW1-1:0] addr1;
    logic [3:0]     q1, pi1, pr1, pg1, pb1, r1, g1, b1;
    logic           v1;

    logic [3:0] rom0 [2**AW0];
    logic [3:0] rom1 [2**AW1];

    function automatic logic [11:0] pal(logic [3:0] i);
        return {i ^ 4'h9, ~i, i + 4'd3};
    endfunction

    always @(posedge clk) q0 <= rom0[addr0];
    always @(posedge clk) q1 <= rom1[addr1];
    assign {pr0, pg0, pb0} = pal(pi0);
    assign {pr1, pg1, pb1} = pal(pi1);

    sprite_window_renderer #(
        .SPR_W(SW0), .SPR_H(SH0), .X0(X00), .Y0(Y00), .SCALE_X(SX0), .SCALE_Y(SY0),
        .AW(AW0), .IDX_W(4), .TRANSP_EN(TE0), .TRANSP_IDX(TI0)
    ) dut0 (
        .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .scroll_x(scroll_x), .rom_addr(addr0), .rom_q(q0), .pal_index(pi0),
        .pal_red(pr0), .pal_green(pg0), .pal_blue(pb0),
        .red(r0), .green(g0), .blue(b0), .pix_valid(v0)
    );

    sprite_window_renderer #(
        .SPR_W(SW1), .SPR_H(SH1), .X0(X01), .Y0(Y01), .SCALE_X(SX1), .SCALE_Y(SY1),
        .AW(AW1), .IDX_W(4), .TRANSP_EN(TE1), .TRANSP_IDX(TI1)
    ) dut1 (
        .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .scroll_x(scroll_x), .rom_addr(addr1), .rom_q(q1), .pal_index(pi1),
        .pal_red(pr1), .pal_green(pg1), .pal_blue(pb1),
        .red(r1), .green(g1), .blue(b1), .pix_valid(v1)
    );

    // scoreboard
    logic [12:0]  exp_q0 [$];
    logic [12:0]  exp_q1 [$];
    logic [AW0:0] exp_a0 [$];
    int total = 0;
    int bad = 0;

    task automatic chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    // reference model
    bit syn0, syn1, cnt_ok0, known0;
    int scl0, scl1, maddr0;

    function automatic bit in_win(int x, int y, int sw, int sh, int x0, int y0, int sx, int sy);
        return x >= x0 && x < x0 + sw * sx && y >= y0 && y < y0 + sh * sy;
    endfunction

    function automatic int texel(int x, int y, int scl, int sw, int x0, int y0, int sx, int sy);
        return ((y - y0) / sy) * sw + (scl + (x - x0) / sx) % sw;
    endfunction

    function automatic logic [12:0] exp_px(bit ok, logic [3:0] idx, int te, int ti);
        if (ok && !(te != 0 && int'(idx) == ti)) return {1'b1, pal(idx)};
        return 13'd0;
    endfunction

    function automatic int sat(int s, int sw);
        return (s > sw - 1) ? sw - 1 : s;
    endfunction

    // driver: one pixel per clock, presented on the falling edge
    task automatic drive_pix(int x, int y, bit blk, bit rst_v, int scr);
        bit iw;
        int a;
        @(negedge clk);
        rst = rst_v;
        draw_x = 10'(x);
        draw_y = 10'(y);
        blank = blk;
        scroll_x = 10'(scr);
        if (rst_v) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_a0.delete();
            syn0 = 0; syn1 = 0; cnt_ok0 = 0;
            scl0 = 0; scl1 = 0;
            maddr0 = 0; known0 = 1;
            return;
        end
        if (x == 0 && y == 0) begin
            scl0 = sat(scr, SW0); scl1 = sat(scr, SW1);
            syn0 = 1; syn1 = 1;
        end
        iw = in_win(x, y, SW0, SH0, X00, Y00, SX0, SY0);
        a = 0;
        if (iw) begin
            a = texel(x, y, scl0, SW0, X00, Y00, SX0, SY0);
            if (x == X00 && y == Y00) cnt_ok0 = 1;
            if (blk) begin
                maddr0 = a;
                known0 = cnt_ok0;
            end
        end
        exp_q0.push_back(exp_px(iw && blk && syn0, rom0[a], TE0, TI0));
        exp_a0.push_back({known0, AW0'(maddr0)});
        iw = in_win(x, y, SW1, SH1, X01, Y01, SX1, SY1);
        a = iw ? texel(x, y, scl1, SW1, X01, Y01, SX1, SY1) : 0;
        exp_q1.push_back(exp_px(iw && blk && syn1, rom1[a], TE1, TI1));
    endtask

    // monitor: outputs for the pixel sampled at edge k appear at edge k+3 (address at k+1)
    initial begin
        logic [12:0]  e;
        logic [AW0:0] ea;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("reset_valid0", int'(v0), 0);
                chk("reset_rgb0", int'({r0, g0, b0}), 0);
                chk("reset_addr0", int'(addr0), 0);
                chk("reset_valid1", int'(v1), 0);
                chk("reset_rgb1", int'({r1, g1, b1}), 0);
            end else begin
                if (exp_q0.size() > 3) begin
                    e = exp_q0.pop_front();
                    chk("pix0", int'({v0, r0, g0, b0}), int'(e));
                end
                if (exp_q1.size() > 3) begin
                    e = exp_q1.pop_front();
                    chk("pix1", int'({v1, r1, g1, b1}), int'(e));
                end
                if (exp_a0.size() > 1) begin
                    ea = exp_a0.pop_front();
                    if (ea[AW0]) chk("addr0", int'(addr0), int'(ea[AW0-1:0]));
                end
            end
        end
    end

    // stimulus
    initial begin
        int scr_tbl [6] = '{0, 0, 5, 6, 700, 9};
        int scr;
        bit blk, rst_now;
        for (int i = 0; i < 2**AW0; i++)
            rom0[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        for (int i = 0; i < 2**AW1; i++)
            rom1[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        scr = 0;
        for (int f = 0; f < NF; f++) begin
            for (int y = 0; y < VT; y++) begin
                for (int x = 0; x < HT; x++) begin
                    if (x == 0)
                        scr = (y == 0) ? scr_tbl[f % 6] :
                              (($urandom_range(0, 7) == 0) ? 700 : int'($urandom_range(0, 15)));
                    blk = (x < HACT) && (y < VACT) && ($urandom_range(0, 15) != 0);
                    rst_now = (f == 0 && y == 0) ||
                              (f == 3 && ((y == 8 && x >= 5) || (y > 8 && y < 11)));
                    drive_pix(x, y, blk, rst_now, scr);
                end
            end
        end
        repeat (6) drive_pix(HT - 2, VT - 1, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
